// File: rtl/cvw_pkg.sv
// Shared cvw package: types and constants used by the RVVI TX arbiter.
//   rvvi_arb_state_t : arbiter FSM state encoding
//   REQ0 / REQ1      : requester index constants (used for the last-grant pointer)
//   STATS_WIDTH      : width of the optional per-requester frame counters
package cvw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } rvvi_arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int STATS_WIDTH = 16;

endpackage

// File: rtl/rvvi_tx_arbiter_counter.sv
// Generic up-counter with synchronous clear, wraps at all-ones.
// Ports:
//   clk, resetn : clock, async active-low reset (count -> 0)
//   clear       : synchronous clear, has priority over en
//   en          : increment enable
//   count       : current count
module rvvi_tx_arbiter_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Two-requester frame arbiter for the shared RVVI MAC W channel.
// Requester 0 is the RVVI packetizer, requester 1 carries host/control frames.
// Whole frames are granted atomically with round-robin between requesters, and
// InterFrameGap idle cycles are inserted after every frame.
// Ports:
//   m_axi_aclk, m_axi_aresetn : clock, async active-low reset
//   Req{0,1}W{data,strb,last,valid}, Req{0,1}Wready : requester W channels
//   RvviAxiW{data,strb,last,valid}, RvviAxiWready   : shared MAC W channel
//   InterFrameGap : idle cycles after each frame (sampled when the frame ends)
//   Enable        : permits new grants (never truncates a frame in progress)
//   Grant         : registered one-hot owner, 00 when none
//   Busy          : FSM not in IDLE
// Optional (macro RVVI_TX_ARB_STATS_EN): Req0Frames/Req1Frames, 16-bit
// wrapping counts of completed frames per requester.
module rvvi_tx_arbiter
  import cvw_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_WIDTH  = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic [DATA_WIDTH-1:0]   Req0Wdata,
  input  logic [DATA_WIDTH/8-1:0] Req0Wstrb,
  input  logic                    Req0Wlast,
  input  logic                    Req0Wvalid,
  output logic                    Req0Wready,
  input  logic [DATA_WIDTH-1:0]   Req1Wdata,
  input  logic [DATA_WIDTH/8-1:0] Req1Wstrb,
  input  logic                    Req1Wlast,
  input  logic                    Req1Wvalid,
  output logic                    Req1Wready,
  output logic [DATA_WIDTH-1:0]   RvviAxiWdata,
  output logic [DATA_WIDTH/8-1:0] RvviAxiWstrb,
  output logic                    RvviAxiWlast,
  output logic                    RvviAxiWvalid,
  input  logic                    RvviAxiWready,
  input  logic [GAP_WIDTH-1:0]    InterFrameGap,
  input  logic                    Enable,
  output logic [1:0]              Grant,
  output logic                    Busy
`ifdef RVVI_TX_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]  Req0Frames,
  output logic [STATS_WIDTH-1:0]  Req1Frames
`endif
);

  localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  rvvi_arb_state_t        state, stateNext;
  logic                   lastGrant;
  logic [GAP_WIDTH-1:0]   gapTarget;
  logic [GAP_WIDTH-1:0]   gapCnt;
  logic                   gapClr, gapEn;
  logic                   frameDone0, frameDone1;

  // Gap counter: cleared as a frame ends (i.e. on GAP entry), then counts GAP cycles.
  rvvi_tx_arbiter_counter #(.WIDTH(GAP_WIDTH)) gapCounter (
    .clk    (m_axi_aclk),
    .resetn (m_axi_aresetn),
    .clear  (gapClr),
    .en     (gapEn),
    .count  (gapCnt)
  );

  always_comb begin
    stateNext     = state;
    RvviAxiWdata  = '0;
    RvviAxiWstrb  = '0;
    RvviAxiWlast  = 1'b0;
    RvviAxiWvalid = 1'b0;
    Req0Wready    = 1'b0;
    Req1Wready    = 1'b0;
    frameDone0    = 1'b0;
    frameDone1    = 1'b0;
    gapClr        = 1'b0;
    gapEn         = 1'b0;
    case (state)
      IDLE: begin
        // Requester 0 wins if it is the only one valid, or if both are
        // valid and requester 1 held the previous grant.
        if (Enable && (Req0Wvalid || Req1Wvalid)) begin
          if (Req0Wvalid && (!Req1Wvalid || lastGrant == REQ1)) stateNext = GRANT0;
          else                                                  stateNext = GRANT1;
        end
      end
      GRANT0: begin
        RvviAxiWdata  = Req0Wdata;
        RvviAxiWstrb  = Req0Wstrb;
        RvviAxiWlast  = Req0Wlast;
        RvviAxiWvalid = Req0Wvalid;
        Req0Wready    = RvviAxiWready;
        if (Req0Wvalid && RvviAxiWready && Req0Wlast) begin
          frameDone0 = 1'b1;
          gapClr     = 1'b1;
          stateNext  = (InterFrameGap != '0) ? GAP : IDLE;
        end
      end
      GRANT1: begin
        RvviAxiWdata  = Req1Wdata;
        RvviAxiWstrb  = Req1Wstrb;
        RvviAxiWlast  = Req1Wlast;
        RvviAxiWvalid = Req1Wvalid;
        Req1Wready    = RvviAxiWready;
        if (Req1Wvalid && RvviAxiWready && Req1Wlast) begin
          frameDone1 = 1'b1;
          gapClr     = 1'b1;
          stateNext  = (InterFrameGap != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        // gapCnt+1 is the 1-based index of the current GAP cycle.
        gapEn = 1'b1;
        if (gapCnt + GAP_ONE == gapTarget) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state     <= IDLE;
      Grant     <= 2'b00;
      lastGrant <= REQ1;
      gapTarget <= '0;
    end else begin
      state <= stateNext;
      Grant <= {stateNext == GRANT1, stateNext == GRANT0};
      if      (state == IDLE && stateNext == GRANT0) lastGrant <= REQ0;
      else if (state == IDLE && stateNext == GRANT1) lastGrant <= REQ1;
      // Gap length is frozen as the frame ends; later input changes are ignored.
      if (gapClr) gapTarget <= InterFrameGap;
    end
  end

  assign Busy = (state != IDLE);

`ifdef RVVI_TX_ARB_STATS_EN
  rvvi_tx_arbiter_counter #(.WIDTH(STATS_WIDTH)) req0FrameCounter (
    .clk    (m_axi_aclk),
    .resetn (m_axi_aresetn),
    .clear  (1'b0),
    .en     (frameDone0),
    .count  (Req0Frames)
  );
  rvvi_tx_arbiter_counter #(.WIDTH(STATS_WIDTH)) req1FrameCounter (
    .clk    (m_axi_aclk),
    .resetn (m_axi_aresetn),
    .clear  (1'b0),
    .en     (frameDone1),
    .count  (Req1Frames)
  );
`else
  logic unusedFrameDone;
  assign unusedFrameDone = frameDone0 ^ frameDone1;
`endif

endmodule

// File: doc/rvvi_tx_arbiter.md
RVVI_TX_ARBITER -- requirements
Module: rvvi_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the W-channel data word.
REQ-002 SHALL have parameter GAP_WIDTH, default 32, meaning the width of the inter-frame gap counter and of InterFrameGap.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: m_axi_aclk input 1, clock; m_axi_aresetn input 1, async active-low reset.
REQ-004 SHALL have Req0Wdata/Req1Wdata, input, DATA_WIDTH each: requester 0 (RVVI packetizer) and requester 1 (host/control frames) data.
REQ-005 SHALL have Req0Wstrb/Req1Wstrb, input, DATA_WIDTH/8 each: byte strobes.
REQ-006 SHALL have Req0Wlast/Req1Wlast, input, 1 each: last word of a frame.
REQ-007 SHALL have Req0Wvalid/Req1Wvalid, input, 1 each: word valid.
REQ-008 SHALL have Req0Wready/Req1Wready, output, 1 each: word accepted.
REQ-009 SHALL have RvviAxiWdata output DATA_WIDTH, RvviAxiWstrb output DATA_WIDTH/8, RvviAxiWlast output 1 and RvviAxiWvalid output 1, forming the shared MAC W channel.
REQ-010 SHALL have RvviAxiWready, input, 1: MAC W-channel ready.
REQ-011 SHALL have InterFrameGap, input, GAP_WIDTH: idle cycles enforced after every frame.
REQ-012 SHALL have Enable, input, 1: permits new grants.
REQ-013 SHALL have Grant, output, 2: one-hot current owner, 00 when no owner.
REQ-014 SHALL have Busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT0, GRANT1 and GAP.
REQ-016 IDLE SHALL transition, when Enable is high and at least one ReqNWvalid is high, to GRANTn for the requester selected by round-robin, and SHALL otherwise stay in IDLE.
REQ-017 Round-robin: when both requesters are valid, the requester not granted last SHALL win; after reset requester 0 SHALL win.
REQ-018 In GRANTn, the RvviAxiW* outputs SHALL be combinational pass-through of requester n, ReqnWready SHALL equal RvviAxiWready, and the other requester's ready SHALL be 0.
REQ-019 GRANTn SHALL exit on the cycle where ReqnWvalid, RvviAxiWready and ReqnWlast are all high: to GAP if InterFrameGap is nonzero, else to IDLE.
REQ-020 GAP SHALL count cycles from 1 and SHALL go to IDLE on the cycle the count reaches InterFrameGap (giving exactly InterFrameGap idle cycles); the counter SHALL clear on GAP entry.
REQ-021 In IDLE and GAP, RvviAxiWvalid SHALL be 0 and both ReqNWready SHALL be 0.
REQ-022 Frame grants SHALL be atomic: deasserting Enable mid-frame SHALL NOT end a grant, and only new grants are blocked.
REQ-023 A grant SHALL persist across wait cycles (ReqnWvalid low) until the last beat.
REQ-024 Grant SHALL be registered and SHALL equal 01 in GRANT0, 10 in GRANT1 and 00 otherwise.
REQ-025 Arbitration latency from a valid in IDLE to the first W beat SHALL be 1 cycle.
REQ-026 InterFrameGap SHALL be sampled on GAP entry, so changes during GAP have no effect.

Reset
REQ-027 On m_axi_aresetn low, asynchronously: state SHALL be IDLE, Grant 00, Busy 0, RvviAxiWvalid 0, both ReqNWready 0, gap counter 0, last-grant pointer set to requester 1 (so requester 0 wins first).
REQ-028 Reset mid-frame SHALL abandon the frame; a truncated frame at the MAC is acceptable.

Configuration
REQ-029 With the macro RVVI_TX_ARB_STATS_EN defined, outputs Req0Frames and Req1Frames (16 bits each, wrap at 0xFFFF to 0) SHALL count completed frames per requester, reset to 0.
REQ-030 Without RVVI_TX_ARB_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 The state enum (rvvi_arb_state_t) and the requester index constants SHALL live in the shared cvw package.
REQ-032 The gap and stats counters SHALL instantiate the existing counter sub-module; no other sub-module is needed.

Verification
REQ-033 Only Req0 sends a 3-word frame, InterFrameGap=4 -> 3 beats with Wlast on beat 3, Grant=01 during the frame, 4 idle cycles, then IDLE.
REQ-034 Req0 and Req1 both valid out of reset, InterFrameGap=0 -> Req0's frame is sent first, then Req1's, with 1 idle cycle between them.
REQ-035 RvviAxiWready held low for 5 cycles mid-frame -> no beat lost or duplicated, Req1Wready stays 0 throughout.
REQ-036 Enable dropped on beat 2 of 4 -> the frame completes, no new grant is issued while Enable=0, and arbitration resumes 1 cycle after Enable=1.
REQ-037 m_axi_aresetn asserted mid-frame -> same cycle: Wvalid=0, Grant=00; after release Req0 wins the next arbitration.
REQ-038 With RVVI_TX_ARB_STATS_EN, 65537 Req1 frames -> Req1Frames=1.
